// File: rtl/aes_pkg.sv
// Shared AES key-expansion types and constants.
// Every stage of the key-schedule datapath imports this package.
package aes_pkg;

  localparam int AES_WORD_BYTES = 4;
  localparam int AES_BYTE_BITS  = 8;
  localparam int AES_WORD_BITS  = AES_WORD_BYTES * AES_BYTE_BITS;

  typedef logic [AES_BYTE_BITS-1:0] aes_byte_t;
  typedef logic [AES_WORD_BITS-1:0] aes_word_t;

  // Occupancy of a single-entry pipeline register.
  typedef enum logic {
    VALID_EMPTY = 1'b0,
    VALID_FULL  = 1'b1
  } validState_t;

endpackage

// File: rtl/aes_rot_bytes.sv
// Combinational byte rotator.
// Rotates the word left by ROT_BYTES whole bytes, or passes it through unchanged when en is high.
module aes_rot_bytes
  import aes_pkg::*;
#(
  parameter int WORD_BYTES = AES_WORD_BYTES,
  parameter int ROT_BYTES  = 1
) (
  input  logic [WORD_BYTES*AES_BYTE_BITS-1:0] w,
  input  logic                                en,
  output logic [WORD_BYTES*AES_BYTE_BITS-1:0] r
);

  logic [WORD_BYTES*AES_BYTE_BITS-1:0] rotated;

  // Output byte i is taken from input byte (i - ROT_BYTES) mod WORD_BYTES.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < WORD_BYTES; i++) begin
      rotated[i*AES_BYTE_BITS +: AES_BYTE_BITS] =
        w[((i + WORD_BYTES - ROT_BYTES) % WORD_BYTES)*AES_BYTE_BITS +: AES_BYTE_BITS];
    end
  end

  assign r = en ? w : rotated;

endmodule

// File: rtl/aes_rotate_word.sv
// Registered AES RotWord stage with a valid/ready handshake on both sides.
// It can accept one word per cycle and adds one cycle of latency.
module aes_rotate_word
  import aes_pkg::*;
#(
  parameter int WORD_BYTES = AES_WORD_BYTES,
  parameter int ROT_BYTES  = 1
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        inValid,
  output logic        inReady,
  input  logic        disableRotate,
  input  logic [31:0] inWord,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] rotWord
);

  generate
    if (ROT_BYTES < 0 || ROT_BYTES >= WORD_BYTES || WORD_BYTES * AES_BYTE_BITS != 32) begin : gBadParams
      $error("aes_rotate_word: unsupported WORD_BYTES/ROT_BYTES combination");
    end
  endgenerate

  validState_t state;
  aes_word_t   nextWord;
  logic        inXfer;
  logic        outXfer;

  aes_rot_bytes #(
    .WORD_BYTES(WORD_BYTES),
    .ROT_BYTES (ROT_BYTES)
  ) uRot (
    .w (inWord),
    .en(disableRotate),
    .r (nextWord)
  );

  assign outValid = (state == VALID_FULL);
  assign inReady  = !outValid || outReady;
  assign inXfer   = inValid && inReady;
  assign outXfer  = outValid && outReady;

  // A new word always wins over a drain, so simultaneous in/out keeps the stage FULL.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= VALID_EMPTY;
      rotWord <= '0;
    end else begin
      case (state)
        VALID_EMPTY: begin
          if (inXfer) begin
            rotWord <= nextWord;
            state   <= VALID_FULL;
          end
        end
        VALID_FULL: begin
          if (inXfer) begin
            rotWord <= nextWord;
            state   <= VALID_FULL;
          end else if (outXfer) begin
            state <= VALID_EMPTY;
          end
        end
        default: state <= VALID_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_rotate_word.sv
// Directed self-checking bench for aes_rotate_word.
module tb_aes_rotate_word;

  logic        clk;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic        disableRotate;
  logic [31:0] inWord;
  logic        outValid;
  logic        outReady;
  logic [31:0] rotWord;

  int checks = 0;
  int errors = 0;

  aes_rotate_word #(
    .WORD_BYTES(4),
    .ROT_BYTES (1)
  ) dut (
    .clk          (clk),
    .rstN         (rstN),
    .inValid      (inValid),
    .inReady      (inReady),
    .disableRotate(disableRotate),
    .inWord       (inWord),
    .outValid     (outValid),
    .outReady     (outReady),
    .rotWord      (rotWord)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic dis, input logic rdy);
    @(negedge clk);
    inValid       = v;
    inWord        = w;
    disableRotate = dis;
    outReady      = rdy;
  endtask

  task automatic waitSample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; inValid = 1'b0; inWord = '0; disableRotate = 1'b0; outReady = 1'b1;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_outValid: got %b expected 0", outValid); end
    checks++; if (rotWord !== 32'h0) begin errors++; $display("[TB] FAIL reset_rotWord: got %h expected 00000000", rotWord); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_inReady: got %b expected 1", inReady); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_out_of_reset();
    @(negedge clk);
    rstN = 1'b1; inValid = 1'b1; inWord = 32'h0A0B0C0D; disableRotate = 1'b0; outReady = 1'b1;
    waitSample();
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL oor_outValid: got %b expected 1", outValid); end
    checks++; if (rotWord !== 32'h0B0C0D0A) begin errors++; $display("[TB] FAIL oor_rotWord: got %h expected 0B0C0D0A", rotWord); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitSample();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL oor_drain: got %b expected 0", outValid); end
  endtask

  task automatic test_rotate();
    applyStimulus(1'b1, 32'hE3771889, 1'b0, 1'b1);
    waitSample();
    checks++; if (outValid !== 1'b1) begin errors++; $display("[TB] FAIL rotate_outValid: got %b expected 1", outValid); end
    checks++; if (rotWord !== 32'h771889E3) begin errors++; $display("[TB] FAIL rotate_rotWord: got %h expected 771889E3", rotWord); end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitSample();
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL rotate_drain: got %b expected 0", outValid); end
    checks++; if (rotWord !== 32'h771889E3) begin errors++; $display("[TB] FAIL rotate_hold: got %h expected 771889E3", rotWord); end
  endtask

  task automatic test_bypass();
    logic [31:0] words [3];
    logic        dis   [3];
    logic [31:0] exp   [3];
    words = '{32'hE3771889, 32'h00000000, 32'hFFFFFFFF};
    dis   = '{1'b1, 1'b0, 1'b0};
    exp   = '{32'hE3771889, 32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, words[i], dis[i], 1'b1);
      waitSample();
      checks++; if (rotWord !== exp[i] || outValid !== 1'b1) begin
        errors++; $display("[TB] FAIL bypass_%0d: got %h/%b expected %h/1", i, rotWord, outValid, exp[i]);
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitSample();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    logic [31:0] exp   [3];
    words = '{32'h01020304, 32'hAABBCCDD, 32'h11223344};
    exp   = '{32'h02030401, 32'hBBCCDDAA, 32'h22334411};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, words[i], 1'b0, 1'b1);
      #1;
      checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_inReady_%0d: got %b expected 1", i, inReady); end
      waitSample();
      checks++; if (rotWord !== exp[i] || outValid !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_word_%0d: got %h/%b expected %h/1", i, rotWord, outValid, exp[i]);
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitSample();
  endtask

  task automatic test_backpressure();
    applyStimulus(1'b1, 32'hE3771889, 1'b0, 1'b1);
    waitSample();
    checks++; if (rotWord !== 32'h771889E3) begin errors++; $display("[TB] FAIL bp_load: got %h expected 771889E3", rotWord); end
    applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0);
    #1;
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_inReady_low: got %b expected 0", inReady); end
    for (int i = 0; i < 3; i++) begin
      waitSample();
      checks++; if (rotWord !== 32'h771889E3 || outValid !== 1'b1 || inReady !== 1'b0) begin
        errors++; $display("[TB] FAIL bp_stall_%0d: got %h/%b/%b expected 771889E3/1/0", i, rotWord, outValid, inReady);
      end
    end
    applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b1);
    #1;
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_inReady_release: got %b expected 1", inReady); end
    waitSample();
    checks++; if (rotWord !== 32'h34567812 || outValid !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_next: got %h/%b expected 34567812/1", rotWord, outValid);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitSample();
    checks++; if (outValid !== 1'b0 || rotWord !== 32'h34567812) begin
      errors++; $display("[TB] FAIL bp_drain: got %h/%b expected 34567812/0", rotWord, outValid);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 32'hAABBCCDD, 1'b0, 1'b0);
    waitSample();
    checks++; if (rotWord !== 32'hBBCCDDAA || outValid !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_load: got %h/%b expected BBCCDDAA/1", rotWord, outValid);
    end
    #2;
    rstN = 1'b0;
    inValid = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_outValid: got %b expected 0", outValid); end
    checks++; if (rotWord !== 32'h0) begin errors++; $display("[TB] FAIL mid_rotWord: got %h expected 00000000", rotWord); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL mid_inReady: got %b expected 1", inReady); end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_out_of_reset();
    test_rotate();
    test_bypass();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_out_of_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_rotate_word.md
# aes_rotate_word

Single-stage registered AES RotWord unit for the key-expansion datapath. Performs a cyclic one-byte left rotation of a 32-bit word, so [a0,a1,a2,a3] becomes [a1,a2,a3,a0]. A bypass control passes the word through unrotated. The unit sits between the key-schedule word buffer and the SubWord/Rcon stage, with a valid/ready handshake on both sides.

## Interface
- `WORD_BYTES`, default 4: bytes per word. Only 4 is supported for AES.
- `ROT_BYTES`, default 1: left-rotation amount in bytes, range 0..`WORD_BYTES`-1.
- `clk` in 1: single clock, rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `inValid` in 1: input word valid.
- `inReady` out 1: unit can accept a word this cycle.
- `disableRotate` in 1: 1 means pass `inWord` through unchanged. Sampled together with `inWord`.
- `inWord` in 32: word to rotate. Byte 3 is bits [31:24].
- `outValid` out 1: `rotWord` holds a valid result.
- `outReady` in 1: downstream accepts `rotWord` this cycle.
- `rotWord` out 32: rotated word, or the bypassed word.

## Operation
- Rotation function: R(w) = {w[23:0], w[31:24]} for `ROT_BYTES`=1. Generally this is a left rotate by 8·`ROT_BYTES` bits.
- Example: E3771889 → 771889E3.
- Output function: f(w) = w if `disableRotate`=1, otherwise R(w).
- Transfer on input: `inValid` && `inReady`.
- Transfer on output: `outValid` && `outReady`.
- `inReady` = !`outValid` || `outReady`. This is combinational and allows full throughput with no bubble.
- On input transfer, at the next edge: `rotWord` ← f(`inWord`), `outValid` ← 1.
- On output transfer with no input transfer: `outValid` ← 0 and `rotWord` holds its last value.
- Output stall (`outValid`=1, `outReady`=0):
  - `rotWord` and `outValid` hold.
  - `inReady`=0, and input is ignored even if `inValid`=1.
- Simultaneous output and input transfer: the new word replaces the old one and `outValid` stays 1.
- `inWord` and `disableRotate` are don't-care when `inValid`=0.
- Arithmetic: pure byte permutation. No carries, no width growth.

## Timing
- Reset (`rstN`=0, asynchronous): `outValid`=0 and `rotWord`=32'h0 immediately. Consequently `inReady`=1.
- Reset release: synchronous to `clk`. The first accept is possible on the first rising edge with `rstN`=1.
- Latency: 1 cycle from input transfer to `outValid`. Throughput: 1 word/cycle.
- Reset mid-operation: any held word is discarded and `outValid` drops immediately, with no partial output.
- No combinational path from `inWord` to `rotWord`. The only combinational path is from `outReady` to `inReady`.
- State: one 2-state valid flag, EMPTY (`outValid`=0) and FULL (`outValid`=1).
  - EMPTY → FULL on input transfer.
  - FULL → EMPTY on output transfer without input transfer.
  - FULL → FULL otherwise.

## Structure
- Shared package `aes_pkg`:
  - `aes_word_t` (logic [31:0])
  - `aes_byte_t`
  - `AES_WORD_BYTES`=4
- Sub-module `aes_rot_bytes`: purely combinational parameterised byte rotator (w, en → r) that computes f.
- The top level owns the data register, the valid flag and the handshake logic.
- Parameter check at elaboration: `ROT_BYTES` < `WORD_BYTES` and `WORD_BYTES`·8 = 32. Elaboration fails otherwise.

## Test plan
- Rotate: `inWord`=E3771889, `disableRotate`=0, `inValid`=1, `outReady`=1 → one cycle later `outValid`=1, `rotWord`=771889E3.
- Bypass: `inWord`=E3771889, `disableRotate`=1 → `rotWord`=E3771889. Also check 00000000 → 00000000 and FFFFFFFF → FFFFFFFF with rotate enabled.
- Back-to-back: stream 01020304, AABBCCDD, 11223344 on consecutive cycles with `outReady`=1 → 02030401, BBCCDDAA, 22334411 on consecutive cycles, with `inReady` held at 1.
- Backpressure:
  - Result 771889E3 is held with `outReady`=0 for 3 cycles → `rotWord` stable, `inReady`=0, and a new `inWord`=12345678 is not accepted.
  - `outReady` is then raised → 771889E3 is consumed, 12345678 is accepted, and 34567812 follows.
- Reset mid-operation: with `outValid`=1, pull `rstN` low between clock edges → `outValid`=0, `rotWord`=0, `inReady`=1 without waiting for a clock edge.
- Out of reset: first accept on the first edge after `rstN` release.
